// File: rtl/verilab_chip_verif_param_pkg.sv
// Shared constants, FSM state type and register-bank sizing helper for the
// behavioural chip stub and its I2C front end.
package verilab_chip_verif_param_pkg;

   localparam int         GPIO          = 8;
   localparam logic [6:0] I2C_ADDR_DFLT = 7'h3C;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } i2c_state_e;

   // Bytes needed to hold one bit per GPIO pin.
   function automatic int gpio_nb(input int n);
      return (n + 7) / 8;
   endfunction

endpackage

// File: rtl/verilab_i2c_edge_sync.sv
// Two-flop synchroniser for SCL/SDA plus one history flop; decodes START,
// STOP and SCL edges from the synchronised levels.
module verilab_i2c_edge_sync (
   input  logic clk,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic start_evt,
   output logic stop_evt,
   output logic scl_rise,
   output logic scl_fall
);
   import verilab_chip_verif_param_pkg::*;

   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;

   // p0/p1: synchroniser, p2: previous level for edge detection
   always_ff @(posedge clk) begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
   end

   assign sda_s     = sda_p1;
   assign start_evt = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
   assign stop_evt  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
   assign scl_rise  = scl_p1 & ~scl_p2;
   assign scl_fall  = ~scl_p1 & scl_p2;

endmodule

// File: rtl/verilab_chip_i2c_gpio_stub.sv
// Behavioural chip stub: weak bus defaults plus an I2C target that programs
// GPIO OUT/OE banks. Read transfers exist only with VERILAB_CHIP_STUB_READBACK_EN.
module verilab_chip_i2c_gpio_stub #(
   parameter int         GPIO     = verilab_chip_verif_param_pkg::GPIO,
   parameter logic [6:0] I2C_ADDR = verilab_chip_verif_param_pkg::I2C_ADDR_DFLT
) (
   input  logic            clk,
   input  logic            reset,
   inout  wire             i2c_scl,
   inout  wire             i2c_sda,
   inout  wire  [GPIO-1:0] gpio,
   output logic            busy
);
   import verilab_chip_verif_param_pkg::*;

   localparam int NB   = gpio_nb(GPIO);
   localparam int NREG = 2 * NB;
   localparam int PW   = $clog2(NREG);
`ifdef VERILAB_CHIP_STUB_READBACK_EN
   localparam bit RD_EN = 1'b1;
   localparam int BW    = NB * 8;
`else
   localparam bit RD_EN = 1'b0;
`endif

   i2c_state_e      state_q, state_nxt;
   logic [3:0]      bit_cnt_q;
   logic [PW-1:0]   ptr_q, ptr_inc;
   logic [GPIO-1:0] out_q, oe_q;
   logic            busy_q;
   logic [7:0]      shreg_q, rx_byte;
   logic            sda_low, sda_s, start_evt, stop_evt, scl_rise, scl_fall;
   logic            rx_state, rx_shift, byte_done, tx_shift, ptr_adv;

   verilab_i2c_edge_sync u_sync (
      .clk       (clk),
      .scl       (i2c_scl),
      .sda       (i2c_sda),
      .sda_s     (sda_s),
      .start_evt (start_evt),
      .stop_evt  (stop_evt),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall)
   );

   // Open-drain style pins: only weak defaults unless actively driving
   pullup (i2c_scl);
   pullup (i2c_sda);
   assign i2c_sda = sda_low ? 1'b0 : 1'bz;

   for (genvar g = 0; g < GPIO; g++) begin : g_pin
      pulldown (gpio[g]);
      assign gpio[g] = oe_q[g] ? out_q[g] : 1'bz;
   end

   assign busy      = busy_q;
   assign rx_state  = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
   assign rx_shift  = rx_state && scl_rise && (bit_cnt_q < 4'd8);
   assign byte_done = rx_shift && (bit_cnt_q == 4'd7);
   assign rx_byte   = {shreg_q[6:0], sda_s};
   assign ptr_inc   = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + 1'b1;

`ifdef VERILAB_CHIP_STUB_READBACK_EN
   logic [GPIO-1:0] gpio_p0, gpio_p1;
   logic [BW-1:0]   pin_pad, oe_pad;
   logic [PW-1:0]   rd_ptr;
   logic [7:0]      rd_byte, tx_q;
   logic            rw_q;

   assign tx_shift = (state_q == ST_RDATA) && scl_fall;
   assign ptr_adv  = scl_fall && ((state_q == ST_WDATA_ACK) || (state_q == ST_RDATA_ACK));
   assign pin_pad  = BW'(gpio_p1);
   assign oe_pad   = BW'(oe_q);
   // Next byte is fetched at the same edge the pointer advances
   assign rd_ptr   = (state_q == ST_RDATA_ACK) ? ptr_inc : ptr_q;

   always_comb begin
      rd_byte = '0;
      for (int b = 0; b < NB; b++) begin
         if (rd_ptr == PW'(b))      rd_byte = pin_pad[b*8 +: 8];
         if (rd_ptr == PW'(NB + b)) rd_byte = oe_pad[b*8 +: 8];
      end
   end
`else
   assign tx_shift = 1'b0;
   assign ptr_adv  = scl_fall && (state_q == ST_WDATA_ACK);
`endif

   always_comb begin
      state_nxt = state_q;
      if (start_evt) begin
         state_nxt = ST_ADDR;
      end else if (stop_evt) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_q)
            ST_ADDR:
               if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (shreg_q[7:1] == I2C_ADDR && (!shreg_q[0] || RD_EN))
                     state_nxt = ST_ADDR_ACK;
                  else
                     state_nxt = ST_IGNORE;
               end
            ST_ADDR_ACK:
               if (scl_fall) begin
`ifdef VERILAB_CHIP_STUB_READBACK_EN
                  state_nxt = rw_q ? ST_RDATA : ST_PTR;
`else
                  state_nxt = ST_PTR;
`endif
               end
            ST_PTR:
               if (scl_fall && bit_cnt_q == 4'd8) state_nxt = ST_PTR_ACK;
            ST_PTR_ACK, ST_WDATA_ACK:
               if (scl_fall) state_nxt = ST_WDATA;
            ST_WDATA:
               if (scl_fall && bit_cnt_q == 4'd8) state_nxt = ST_WDATA_ACK;
`ifdef VERILAB_CHIP_STUB_READBACK_EN
            ST_RDATA:
               if (scl_fall && bit_cnt_q == 4'd7) state_nxt = ST_RDATA_ACK;
            ST_RDATA_ACK:
               if (scl_rise && sda_s)  state_nxt = ST_IGNORE;
               else if (scl_fall)      state_nxt = ST_RDATA;
`endif
            default: state_nxt = state_q;
         endcase
      end
   end

   always_comb begin
      sda_low = 1'b0;
      case (state_q)
         ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_low = 1'b1;
`ifdef VERILAB_CHIP_STUB_READBACK_EN
         ST_RDATA: sda_low = ~tx_q[7];
`endif
         default: sda_low = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         ptr_q     <= '0;
         out_q     <= '0;
         oe_q      <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (start_evt || state_nxt != state_q)
            bit_cnt_q <= '0;
         else if (rx_shift || tx_shift)
            bit_cnt_q <= bit_cnt_q + 4'd1;

         if (state_q == ST_PTR && byte_done)
            ptr_q <= PW'(rx_byte % 8'(NREG));
         else if (ptr_adv)
            ptr_q <= ptr_inc;

         // Bits beyond GPIO in the top byte have no storage, so they read 0
         if (state_q == ST_WDATA && byte_done) begin
            for (int i = 0; i < GPIO; i++) begin
               if (ptr_q == PW'(i / 8))      out_q[i] <= rx_byte[3'(i % 8)];
               if (ptr_q == PW'(NB + i / 8)) oe_q[i]  <= rx_byte[3'(i % 8)];
            end
         end

         if (state_nxt == ST_IDLE || state_nxt == ST_IGNORE)
            busy_q <= 1'b0;
         else if (state_q == ST_ADDR_ACK)
            busy_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_shift) shreg_q <= rx_byte;
`ifdef VERILAB_CHIP_STUB_READBACK_EN
      gpio_p0 <= gpio;
      gpio_p1 <= gpio_p0;
      if (state_q == ST_ADDR && state_nxt == ST_ADDR_ACK) rw_q <= shreg_q[0];
      if (state_nxt == ST_RDATA && state_q != ST_RDATA)
         tx_q <= rd_byte;
      else if (tx_shift)
         tx_q <= {tx_q[6:0], 1'b0};
`endif
   end

endmodule

// File: tb/tb_verilab_chip_i2c_gpio_stub.sv
// Directed bench for the I2C GPIO chip stub: a write-transaction table plus
// hand sequences for read-back, pointer wrap and mid-transfer reset.
module tb_verilab_chip_i2c_gpio_stub;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_pull = 1'b0;
   logic       sda_pull = 1'b0;
   wire        i2c_scl;
   wire        i2c_sda;
   wire  [7:0] gpio;
   logic       busy;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] gpio_hi;
   logic       sda_post;

   always #5 clk = ~clk;

   assign i2c_scl = scl_pull ? 1'b0 : 1'bz;
   assign i2c_sda = sda_pull ? 1'b0 : 1'bz;

   verilab_chip_i2c_gpio_stub #(
      .GPIO     (8),
      .I2C_ADDR (7'h3C)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i2c_scl (i2c_scl),
      .i2c_sda (i2c_sda),
      .gpio    (gpio),
      .busy    (busy)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ptr;
      logic [7:0] data;
      logic       exp_ack;
      logic [7:0] exp_gpio;
   } wvec_t;

   wvec_t vecs[5];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      tick(4);
      sda_pull = ~b;
      tick(4);
      scl_pull = 1'b0;
      tick(8);
      gpio_hi  = gpio;
      scl_pull = 1'b1;
   endtask

   task automatic recv_bit(output logic b);
      tick(4);
      sda_pull = 1'b0;
      tick(4);
      scl_pull = 1'b0;
      tick(4);
      b = i2c_sda;
      tick(4);
      scl_pull = 1'b1;
      tick(6);
      sda_post = i2c_sda;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
   endtask

   // Works from idle (SCL high) and as a repeated START (SCL low)
   task automatic start_cond();
      if (scl_pull) begin
         tick(4);
         sda_pull = 1'b0;
         tick(4);
         scl_pull = 1'b0;
         tick(8);
      end
      sda_pull = 1'b1;
      tick(8);
      scl_pull = 1'b1;
      tick(4);
   endtask

   task automatic stop_cond();
      tick(4);
      sda_pull = 1'b1;
      tick(4);
      scl_pull = 1'b0;
      tick(8);
      sda_pull = 1'b0;
      tick(8);
   endtask

   initial begin
      logic       a0, a1, a2, a3, a4;
      logic       busy_mid;
      logic [7:0] rd0, rd1;

      vecs[0] = '{addr: 8'h78, ptr: 8'h01, data: 8'hFF, exp_ack: 1'b1, exp_gpio: 8'h00};
      vecs[1] = '{addr: 8'h78, ptr: 8'h00, data: 8'hA5, exp_ack: 1'b1, exp_gpio: 8'hA5};
      vecs[2] = '{addr: 8'h42, ptr: 8'h55, data: 8'h55, exp_ack: 1'b0, exp_gpio: 8'hA5};
      vecs[3] = '{addr: 8'h78, ptr: 8'h03, data: 8'h0F, exp_ack: 1'b1, exp_gpio: 8'h05};
      vecs[4] = '{addr: 8'h78, ptr: 8'h01, data: 8'hFF, exp_ack: 1'b1, exp_gpio: 8'hA5};

      reset = 1'b1;
      tick(4);
      reset = 1'b0;
      tick(4);
      chk("reset_gpio", gpio, 8'h00);
      chk("reset_sda", {7'd0, i2c_sda}, 8'h01);
      chk("reset_scl", {7'd0, i2c_scl}, 8'h01);
      chk("reset_busy", {7'd0, busy}, 8'h00);

      for (int v = 0; v < 5; v++) begin
         start_cond();
         write_byte(vecs[v].addr, a0);
         busy_mid = busy;
         write_byte(vecs[v].ptr, a1);
         write_byte(vecs[v].data, a2);
         chk($sformatf("v%0d_addr_ack", v), {7'd0, a0}, {7'd0, vecs[v].exp_ack});
         chk($sformatf("v%0d_ptr_ack", v), {7'd0, a1}, {7'd0, vecs[v].exp_ack});
         chk($sformatf("v%0d_data_ack", v), {7'd0, a2}, {7'd0, vecs[v].exp_ack});
         chk($sformatf("v%0d_busy_mid", v), {7'd0, busy_mid}, {7'd0, vecs[v].exp_ack});
         chk($sformatf("v%0d_gpio_pre_ack", v), gpio_hi, vecs[v].exp_gpio);
         chk($sformatf("v%0d_ack_release", v), {7'd0, sda_post}, 8'h01);
         stop_cond();
         chk($sformatf("v%0d_gpio", v), gpio, vecs[v].exp_gpio);
         chk($sformatf("v%0d_busy_end", v), {7'd0, busy}, 8'h00);
      end

      // Pointer set by a write, then a repeated START into a read
      start_cond();
      write_byte(8'h78, a0);
      write_byte(8'h00, a1);
      chk("rd_setup_ack0", {7'd0, a0}, 8'h01);
      chk("rd_setup_ack1", {7'd0, a1}, 8'h01);
      start_cond();
      write_byte(8'h79, a2);
`ifdef VERILAB_CHIP_STUB_READBACK_EN
      chk("rd_addr_ack", {7'd0, a2}, 8'h01);
      read_byte(rd0);
      send_bit(1'b0);
      read_byte(rd1);
      send_bit(1'b1);
      tick(2);
      chk("rd_byte0", rd0, 8'hA5);
      chk("rd_byte1", rd1, 8'hFF);
      chk("rd_busy_after_nack", {7'd0, busy}, 8'h00);
`else
      chk("rd_addr_nack", {7'd0, a2}, 8'h00);
      chk("rd_busy_after_nack", {7'd0, busy}, 8'h00);
`endif
      stop_cond();
      chk("rd_gpio_kept", gpio, 8'hA5);

      // Three data bytes from pointer 1 wrap onto byte 0 and back
      start_cond();
      write_byte(8'h78, a0);
      write_byte(8'h01, a1);
      write_byte(8'h0F, a2);
      write_byte(8'h3C, a3);
      chk("wrap_mid_gpio", gpio_hi, 8'h0C);
      write_byte(8'hF0, a4);
      chk("wrap_acks", {3'd0, a0, a1, a2, a3, a4}, 8'h1F);
      chk("wrap_pre_ack_gpio", gpio_hi, 8'h30);
      stop_cond();
      chk("wrap_gpio", gpio, 8'h30);

      // Reset while the target holds the address ACK
      start_cond();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h78 >> i));
      tick(4);
      sda_pull = 1'b0;
      tick(4);
      scl_pull = 1'b0;
      tick(4);
      chk("rst_ack_low", {7'd0, i2c_sda}, 8'h00);
      reset = 1'b1;
      tick(1);
      chk("rst_sda_released", {7'd0, i2c_sda}, 8'h01);
      chk("rst_gpio", gpio, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      reset = 1'b0;
      tick(4);
      scl_pull = 1'b1;
      tick(6);
      write_byte(8'h78, a0);
      write_byte(8'h00, a1);
      write_byte(8'hFF, a2);
      chk("post_rst_no_ack", {5'd0, a0, a1, a2}, 8'h00);
      chk("post_rst_busy", {7'd0, busy}, 8'h00);
      stop_cond();
      chk("post_rst_gpio", gpio, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
